// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
//   Samples an asynchronous serial line and deframes 12-bit UART frames:
//   start(0), d0..d7 LSB first, parity, stop1(1), stop2(1).
//   The received byte is presented with a one-cycle valid pulse, together
//   with parity and framing status for that frame.
//
// Ports
//   clk         system clock
//   reset       synchronous active-high reset
//   rx_in       serial line, idle high, asynchronous to clk
//   parity_sel  0 = even parity, 1 = odd parity (latched at start bit)
//   rx_data     last received byte (held until next rx_valid)
//   rx_valid    one-cycle pulse when a frame completes
//   parity_err  parity mismatch in last frame, valid with rx_valid
//   frame_err   a stop bit sampled 0 in last frame, valid with rx_valid
//   busy        high whenever the receiver is not idle
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       parity_sel,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MID = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        WAIT_HIGH
    } state_t;

    state_t        state_reg;
    logic [1:0]    sync_reg;      // [0] first stage, [1] synchronized line
    logic          rxs;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bidx_reg;
    logic [7:0]    shift_reg;
    logic          sel_reg;       // parity mode frozen for the frame in flight
    logic          par_bad_reg;
    logic          stop1_bad_reg;

    assign rxs  = sync_reg[1];
    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            sync_reg      <= 2'b11;
            cnt_reg       <= '0;
            bidx_reg      <= '0;
            shift_reg     <= '0;
            sel_reg       <= 1'b0;
            par_bad_reg   <= 1'b0;
            stop1_bad_reg <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], rx_in};
            rx_valid <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (!rxs) begin
                        state_reg <= START;
                        cnt_reg   <= '0;
                    end
                end

                START: begin
                    // Re-check the line at mid start bit to reject glitches.
                    if (cnt_reg == CNT_MID) begin
                        if (!rxs) begin
                            sel_reg   <= parity_sel;
                            cnt_reg   <= '0;
                            bidx_reg  <= '0;
                            state_reg <= DATA;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end

                DATA: begin
                    if (cnt_reg == CNT_END) begin
                        cnt_reg   <= '0;
                        // Shift right so d0 lands in bit 0 after eight bits.
                        shift_reg <= {rxs, shift_reg[7:1]};
                        if (bidx_reg == 3'd7) begin
                            state_reg <= PARITY;
                        end else begin
                            bidx_reg <= bidx_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end

                PARITY: begin
                    if (cnt_reg == CNT_END) begin
                        cnt_reg     <= '0;
                        par_bad_reg <= (rxs != ((^shift_reg) ^ sel_reg));
                        state_reg   <= STOP1;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end

                STOP1: begin
                    if (cnt_reg == CNT_END) begin
                        cnt_reg       <= '0;
                        stop1_bad_reg <= ~rxs;
                        state_reg     <= STOP2;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end

                STOP2: begin
                    if (cnt_reg == CNT_END) begin
                        cnt_reg    <= '0;
                        rx_data    <= shift_reg;
                        parity_err <= par_bad_reg;
                        frame_err  <= stop1_bad_reg | ~rxs;
                        rx_valid   <= 1'b1;
                        // A low stop2 means a break or stuck line: wait for
                        // it to return high so it is not taken as a start bit.
                        state_reg  <= rxs ? IDLE : WAIT_HIGH;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end

                WAIT_HIGH: begin
                    if (rxs) begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer
//   Drives directed UART frames into uart_rx_deframer. Expected frame results
//   are queued when a frame is issued; a negedge monitor pops and compares
//   them whenever rx_valid is seen.
module tb_uart_rx_deframer;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic       parity_sel;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    uart_rx_deframer #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .parity_sel (parity_sel),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       busy;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    int   valid_cyc_q[$];
    int   vecs = 0;
    int   miscompares = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            check("rx_valid_single_cycle", {31'd0, prev_valid}, 32'd0);
            valid_cyc_q.push_back(cyc);
            check("sb_has_expected_frame", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb_q.size() > 0) begin
                sb_e = sb_q.pop_front();
                check("rx_data", {24'd0, rx_data}, {24'd0, sb_e.data});
                check("parity_err", {31'd0, parity_err}, {31'd0, sb_e.perr});
                check("frame_err", {31'd0, frame_err}, {31'd0, sb_e.ferr});
                check("busy_at_valid", {31'd0, busy}, {31'd0, sb_e.busy});
                $display("frame: data=%02h perr=%0b ferr=%0b busy=%0b at cycle %0d",
                         rx_data, parity_err, frame_err, busy, cyc);
            end
        end
        prev_valid = rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input int n);
        rx_in = b;
        tick(n);
    endtask

    // Sends one frame; stop2 is held for s2_len cycles. flip toggles
    // parity_sel during d4 to show it does not affect the frame in flight.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s1,
                              input logic s2, input int s2_len, input bit flip);
        send_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            if (flip && i == 4) parity_sel = ~parity_sel;
            send_bit(d[i], CPB);
        end
        send_bit(p, CPB);
        send_bit(s1, CPB);
        send_bit(s2, s2_len);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic perr, input logic ferr,
                                input logic b);
        sb_q.push_back({d, perr, ferr, b});
    endtask

    task automatic summary;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        miscompares++;
        summary();
        $fatal(1, "watchdog");
    end

    int start_cyc;

    initial begin
        rx_in      = 1'b1;
        parity_sel = 1'b0;
        reset      = 1'b1;
        tick(3);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_parity_err", {31'd0, parity_err}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick(5);

        // 0xA5, even parity, latency from start edge
        valid_cyc_q.delete();
        expect_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        start_cyc = cyc;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, CPB, 1'b0);
        check("a5_pulse_count", valid_cyc_q.size(), 32'd1);
        if (valid_cyc_q.size() > 0)
            check("a5_latency", valid_cyc_q[0] - start_cyc, 32'd187);
        check("a5_busy_after", {31'd0, busy}, 32'd0);
        tick(4);

        // Odd parity: correct then wrong parity bit
        parity_sel = 1'b1;
        expect_frame(8'h01, 1'b0, 1'b0, 1'b0);
        send_frame(8'h01, 1'b0, 1'b1, 1'b1, CPB, 1'b0);
        expect_frame(8'h01, 1'b1, 1'b0, 1'b0);
        send_frame(8'h01, 1'b1, 1'b1, 1'b1, CPB, 1'b0);
        tick(4);

        // parity_sel flipped mid-frame: frame still checked as even
        parity_sel = 1'b0;
        expect_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, CPB, 1'b1);
        parity_sel = 1'b0;
        tick(4);

        // stop2 low for 40 cycles: frame error, WAIT_HIGH until release
        expect_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 40, 1'b0);
        check("wait_high_busy", {31'd0, busy}, 32'd1);
        rx_in = 1'b1;
        tick(4);
        check("wait_high_released", {31'd0, busy}, 32'd0);
        tick(20);

        // stop1 low only: frame error, back to IDLE directly
        expect_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, CPB, 1'b0);
        tick(4);

        // Glitch: 4 low cycles must not start a frame
        valid_cyc_q.delete();
        rx_in = 1'b0;
        tick(4);
        check("glitch_busy_start", {31'd0, busy}, 32'd1);
        rx_in = 1'b1;
        tick(CPB / 2 + 3);
        check("glitch_busy_cleared", {31'd0, busy}, 32'd0);
        tick(20);
        check("glitch_no_pulse", valid_cyc_q.size(), 32'd0);

        // Back-to-back 0xFF then 0x00
        valid_cyc_q.delete();
        expect_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        expect_frame(8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1, CPB, 1'b0);
        send_frame(8'h00, 1'b0, 1'b1, 1'b1, CPB, 1'b0);
        tick(4);
        check("b2b_pulse_count", valid_cyc_q.size(), 32'd2);
        if (valid_cyc_q.size() == 2)
            check("b2b_spacing", valid_cyc_q[1] - valid_cyc_q[0], 32'd192);
        tick(10);

        // Leave non-zero outputs before the reset test: wrong parity + bad stop1
        expect_frame(8'hC3, 1'b1, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b1, CPB, 1'b0);
        tick(10);

        // Reset during d4 of 0x55, then a clean 0x96
        valid_cyc_q.delete();
        send_bit(1'b0, CPB);
        send_bit(1'b1, CPB);
        send_bit(1'b0, CPB);
        send_bit(1'b1, CPB);
        send_bit(1'b0, CPB);
        send_bit(1'b1, CPB / 2);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        rx_in = 1'b1;
        check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
        check("midreset_parity_err", {31'd0, parity_err}, 32'd0);
        check("midreset_frame_err", {31'd0, frame_err}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        tick(40);
        check("midreset_no_pulse", valid_cyc_q.size(), 32'd0);
        expect_frame(8'h96, 1'b0, 1'b0, 1'b0);
        send_frame(8'h96, 1'b0, 1'b1, 1'b1, CPB, 1'b0);
        tick(10);
        check("post_reset_pulse_count", valid_cyc_q.size(), 32'd1);

        check("sb_drained", sb_q.size(), 32'd0);
        summary();
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
Receive-side counterpart of the UART transmit path. It samples a serial line and deframes the 12-bit frame the transmitter emits:
- start bit 0
- data d0..d7, LSB first
- parity bit
- two stop bits, both 1

It checks parity and stop bits and presents the byte with a one-cycle valid pulse. The block sits between the external RX pin and the byte consumer, with no handshake back-pressure.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; even, >= 4.

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
rx_in  input  1  serial line, idle high, asynchronous to clk
parity_sel  input  1  0 = parity bit equals XOR of data (even); 1 = parity bit equals inverted XOR (odd)
rx_data  output  8  last received byte
rx_valid  output  1  one-cycle pulse when a frame completes
parity_err  output  1  parity mismatch in last frame; valid with rx_valid
frame_err  output  1  either stop bit sampled 0 in last frame; valid with rx_valid
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous, active-high, named reset. At reset, rx_data=0, rx_valid=0, parity_err=0, frame_err=0, busy=0, FSM=IDLE, synchronizer flops=1.
- Synchronizer: rx_in passes through a 2-flop synchronizer, reset value 1. All sampling uses the synchronized value rxs.
- Counters:
  - Bit-timing counter cnt, width $clog2(CLKS_PER_BIT).
  - Bit index bidx, 0..7.
  - Data shift register: shifts right, new bit into MSB, so d0 ends at rx_data[0].
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
  - IDLE: when rxs=0, go to START and clear cnt.
  - START: when cnt reaches CLKS_PER_BIT/2-1 (mid-bit):
    - if rxs=0: latch parity_sel into an internal register, clear cnt and bidx, go to DATA;
    - if rxs=1: false start, return to IDLE with no outputs changed.
  - DATA: sample rxs when cnt reaches CLKS_PER_BIT-1, then clear cnt. After bidx=7, go to PARITY; otherwise increment bidx.
  - PARITY: sample at CLKS_PER_BIT-1 into the internal expected/received parity compare, then go to STOP1.
  - STOP1: sample at CLKS_PER_BIT-1, record whether the bit was 0, go to STOP2.
  - STOP2: sample at CLKS_PER_BIT-1. On the next edge:
    - register rx_data and parity_err;
    - set frame_err = (stop1==0) OR (stop2==0);
    - pulse rx_valid for exactly 1 cycle;
    - go to IDLE if the stop2 sample was 1, else go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then go to IDLE. This prevents a break or stuck-low line from re-triggering frames.
- Parity check: expected parity = (^data) XOR latched_parity_sel. parity_err = (received parity != expected parity).
- Output holding:
  - rx_data, parity_err and frame_err hold until the next rx_valid.
  - They are updated on every completed frame, including errored ones.
  - rx_valid is never high on two consecutive cycles.
- Timing: rx_valid rises exactly 2 + CLKS_PER_BIT/2 + 11*CLKS_PER_BIT + 1 cycles after the rx_in falling edge of the start bit, when that edge is aligned to clk. This is 187 cycles for CLKS_PER_BIT=16.
- parity_sel changes mid-frame have no effect on the frame in progress.
- Back-to-back frames: a new start bit arriving immediately after STOP2 is detected with no lost frame.
- Reset mid-frame: an asserted reset in any state returns to IDLE on the next edge, with outputs at reset values and no rx_valid pulse.

Test Plan:
- CLKS_PER_BIT=16, parity_sel=0, send 0xA5 as frame bits 0,1,0,1,0,0,1,0,1,0,1,1 (parity 0) -> rx_valid pulses once, 187 cycles after the start edge; rx_data=0xA5, parity_err=0, frame_err=0; busy falls after the pulse.
- parity_sel=1, send 0x01 with parity bit 0 (correct odd-parity value) -> rx_data=0x01, parity_err=0. Resend with parity bit 1 -> parity_err=1, rx_data=0x01.
- Send 0x3C with stop2 held 0, then release the line high after 40 cycles -> rx_valid with frame_err=1, rx_data=0x3C; FSM sits in WAIT_HIGH until the line rises; no spurious second frame.
- Glitch: rx_in low for 4 cycles, then high -> no rx_valid; busy returns to 0 within CLKS_PER_BIT/2 + 3 cycles.
- Back-to-back frames 0xFF then 0x00 with no idle gap, parity_sel=0 -> two rx_valid pulses exactly 192 cycles apart, with rx_data 0xFF then 0x00, both error-free.
- Assert reset for 1 cycle during data bit 4 of a frame for 0x55, then send a full frame for 0x96 -> outputs cleared; no pulse for the aborted frame; next pulse carries rx_data=0x96.
